// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the alu_seq execute unit.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// (and flush is low); a result transfers on a rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low, the
// result and flags stay constant. flush aborts any held or in-flight
// operation and wins over a request presented in the same cycle.
//
// Signals: in_valid/in_ready, op {mext, instr[30], funct3}, a, b, flush,
// out_valid/out_ready, result, zflag/nflag/cflag/oflag.
// master = the pipeline that issues operations and consumes results,
// slave  = the execute unit.
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zflag;
    logic            nflag;
    logic            cflag;
    logic            oflag;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, zflag, nflag, cflag, oflag
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, zflag, nflag, cflag, oflag
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage execute unit. Base integer ops finish in one
// cycle; RV32M multiply (shift-add) and divide (restoring) iterate XLEN
// cycles. Results and flags are registered and held until consumed.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - alu_seq_if.slave (request, operands, flush, result, flags)
//   dbg_state - current FSM state (IDLE/MUL/DIV/HOLD) for observation
//
// The interface instance must be built with the same XLEN as this module.
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] hi, lo, opnd;   // mul: {hi,lo}=partial product; div: hi=rem, lo=dividend/quotient
    logic            neg_q, neg_r, sel;
    logic            out_valid_q, z_q, n_q, c_q, o_q;
    logic [XLEN-1:0] result_q;

    logic [2:0]      f3;
    logic            mext, accept;
    assign f3        = bus.op[2:0];
    assign mext      = bus.op[4];
    assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign accept    = bus.in_valid && bus.in_ready && !bus.flush;

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zflag     = z_q;
    assign bus.nflag     = n_q;
    assign bus.cflag     = c_q;
    assign bus.oflag     = o_q;
    assign dbg_state     = state;

    // Single-cycle base operations.
    logic [XLEN-1:0] base_res;
    logic            base_c, base_o;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] dif;
    logic [SHW-1:0]  shamt;
    always_comb begin
        base_res = '0;
        base_c   = 1'b0;
        base_o   = 1'b0;
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        dif      = bus.a - bus.b;
        shamt    = bus.b[SHW-1:0];
        case (bus.op[3:0])
            4'b0000: begin
                base_res = sum[XLEN-1:0];
                base_c   = sum[XLEN];
                base_o   = (bus.a[XLEN-1] == bus.b[XLEN-1]) && (sum[XLEN-1] != bus.a[XLEN-1]);
            end
            4'b1000: begin
                base_res = dif;
                base_c   = (bus.a >= bus.b);   // no borrow
                base_o   = (bus.a[XLEN-1] != bus.b[XLEN-1]) && (dif[XLEN-1] != bus.a[XLEN-1]);
            end
            4'b0001: base_res = bus.a << shamt;
            4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b0011: base_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            4'b0100: base_res = bus.a ^ bus.b;
            4'b0101: base_res = bus.a >> shamt;
            4'b1101: base_res = $signed(bus.a) >>> shamt;
            4'b0110: base_res = bus.a | bus.b;
            4'b0111: base_res = bus.a & bus.b;
            default: base_res = '0;
        endcase
    end

    // M-extension setup: operand signedness, magnitudes and divide fast paths.
    logic            a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    always_comb begin
        a_sgn    = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
        b_sgn    = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
        a_neg    = a_sgn && bus.a[XLEN-1];
        b_neg    = b_sgn && bus.b[XLEN-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        is_div   = f3[2];
        div_zero = (bus.b == '0);
        div_ovf  = !f3[0] && (bus.a == MIN) && (bus.b == ONES);
        fast     = is_div && (div_zero || div_ovf);
        // f3[1] selects the remainder form (REM/REMU).
        if (div_zero) fast_res = f3[1] ? bus.a : ONES;
        else          fast_res = f3[1] ? '0 : bus.a;
    end

    // One iteration step plus the sign-corrected final value of each unit.
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [2*XLEN-1:0] prod, prod_s;
    logic              ge;
    logic [XLEN-1:0]   hi_n, lo_n, quo_f, rem_f, fin_res;
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        prod    = {mul_sum, lo[XLEN-1:1]};
        prod_s  = neg_q ? -prod : prod;
        rem_sh  = {hi, lo[XLEN-1]};
        ge      = (rem_sh >= {1'b0, opnd});
        if (state == DIV) begin
            // The trial difference fits in XLEN bits whenever it is kept.
            hi_n = ge ? (rem_sh[XLEN-1:0] - opnd) : rem_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
        quo_f = neg_q ? -lo_n : lo_n;
        rem_f = neg_r ? -hi_n : hi_n;
        if (state == DIV) fin_res = sel ? rem_f : quo_f;
        else              fin_res = sel ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end

    // Value loaded into the output registers when a result completes.
    logic [XLEN-1:0] load_res;
    logic            load_c, load_o;
    always_comb begin
        load_res = base_res;
        load_c   = base_c;
        load_o   = base_o;
        if (state == MUL || state == DIV) begin
            load_res = fin_res;
            load_c   = 1'b0;
            load_o   = 1'b0;
        end else if (mext) begin
            load_res = fast_res;
            load_c   = 1'b0;
            load_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            sel         <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            o_q         <= 1'b0;
        end else if (bus.flush) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        cnt <= '0;
                        if (mext && !fast) begin
                            state       <= is_div ? DIV : MUL;
                            out_valid_q <= 1'b0;
                            hi          <= '0;
                            lo          <= a_mag;
                            opnd        <= b_mag;
                            neg_q       <= a_neg ^ b_neg;
                            neg_r       <= a_neg;
                            sel         <= is_div ? f3[1] : (f3[1:0] != 2'b00);
                        end else begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                            result_q    <= load_res;
                            z_q         <= (load_res == '0);
                            n_q         <= load_res[XLEN-1];
                            c_q         <= load_c;
                            o_q         <= load_o;
                        end
                    end else if (state == HOLD && bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt + 1'b1;
                    hi  <= hi_n;
                    lo  <= lo_n;
                    if (cnt == SHW'(XLEN-1)) begin
                        state       <= HOLD;
                        out_valid_q <= 1'b1;
                        result_q    <= load_res;
                        z_q         <= (load_res == '0);
                        n_q         <= load_res[XLEN-1];
                        c_q         <= load_c;
                        o_q         <= load_o;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (XLEN=32). Expected results,
// flags and latencies come from a behavioural model using wide arithmetic.
module tb_alu_seq;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;

    alu_seq_if #(.XLEN(32)) bus ();

    alu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        o;
        int          lat;
    } exp_t;

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, r;
        logic [63:0] xa, xb, p, qv;
        logic [2:0]  f;
        e.res = '0; e.c = 1'b0; e.o = 1'b0; e.lat = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        f  = op[2:0];
        if (!op[4]) begin
            case (op[3:0])
                4'b0000: begin
                    p = {32'b0, a} + {32'b0, b};
                    e.res = p[31:0]; e.c = p[32];
                    r = sa + sb; e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                end
                4'b1000: begin
                    e.res = a - b; e.c = (a >= b);
                    r = sa - sb; e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                end
                4'b0001: e.res = a << b[4:0];
                4'b0010: e.res = {31'b0, $signed(a) < $signed(b)};
                4'b0011: e.res = {31'b0, a < b};
                4'b0100: e.res = a ^ b;
                4'b0101: e.res = a >> b[4:0];
                4'b1101: e.res = $signed(a) >>> b[4:0];
                4'b0110: e.res = a | b;
                4'b0111: e.res = a & b;
                default: e.res = '0;
            endcase
        end else if (!f[2]) begin
            e.lat = 33;
            xa = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
            xb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
            p  = xa * xb;
            e.res = (f == 3'd0) ? p[31:0] : p[63:32];
        end else if (b == 32'd0) begin
            e.res = f[1] ? a : 32'hFFFF_FFFF;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = f[1] ? 32'd0 : a;
        end else begin
            e.lat = 33;
            if (!f[0]) begin
                qv = f[1] ? (sa % sb) : (sa / sb);
                e.res = qv[31:0];
            end else begin
                e.res = f[1] ? (a % b) : (a / b);
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Driver: presents one request from an idle/draining unit and waits
    // (bounded) for the result. Operands are scrambled while busy.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic [3:0] flg,
                         output logic busy_ok);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            bus.a = $urandom; bus.b = $urandom; bus.op = 5'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        flg = {bus.zflag, bus.nflag, bus.cflag, bus.oflag};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.result, bus.zflag, bus.nflag, bus.cflag, bus.oflag} !== 37'd0) begin
            errors++; $display("FAIL reset_outputs got v=%b r=%h flags=%b%b%b%b want all 0",
                bus.out_valid, bus.result, bus.zflag, bus.nflag, bus.cflag, bus.oflag);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL after_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [4:0]  d_op [16];
        logic [31:0] d_a [16];
        logic [31:0] d_b [16];
        logic [31:0] d_exp [16];
        int lat; logic [31:0] res; logic [3:0] flg; logic busy_ok; exp_t e;
        d_op  = '{5'h00, 5'h08, 5'h02, 5'h03, 5'h0D, 5'h05, 5'h10, 5'h11,
                  5'h13, 5'h12, 5'h14, 5'h16, 5'h15, 5'h17, 5'h14, 5'h16};
        d_a   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                  32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
        d_b   = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h21, 32'h21, 32'd2, 32'd2,
                  32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        d_exp = '{32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'hC000_0000, 32'h4000_0000,
                  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 16; i++) begin
            issue(d_op[i], d_a[i], d_b[i], lat, res, flg, busy_ok);
            e = model(d_op[i], d_a[i], d_b[i]);
            checks++;
            if (res !== d_exp[i]) begin errors++; $display("FAIL directed_result[%0d] got %h want %h", i, res, d_exp[i]); end
            checks++;
            if (flg !== {d_exp[i] == 32'd0, d_exp[i][31], e.c, e.o}) begin
                errors++; $display("FAIL directed_flags[%0d] got %b want %b", i, flg, {d_exp[i] == 32'd0, d_exp[i][31], e.c, e.o});
            end
            checks++;
            if (lat != e.lat) begin errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, e.lat); end
            if (e.lat > 1) begin
                checks++;
                if (!busy_ok) begin errors++; $display("FAIL directed_busy_in_ready[%0d] got in_ready=1 want 0", i); end
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] res, a, b; logic [3:0] flg; logic busy_ok; logic [4:0] op; exp_t e;
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 31));
            a = pick(); b = pick();
            issue(op, a, b, lat, res, flg, busy_ok);
            e = model(op, a, b);
            checks++;
            if (res !== e.res || flg !== {e.res == 32'd0, e.res[31], e.c, e.o} || lat != e.lat) begin
                errors++;
                $display("FAIL random[%0d] op=%h a=%h b=%h got r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                    i, op, a, b, res, flg, lat, e.res, {e.res == 32'd0, e.res[31], e.c, e.o}, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] base_ops [10];
        logic [4:0] op; logic [31:0] a, b; exp_t e;
        base_ops = '{5'h00, 5'h08, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h0D, 5'h06, 5'h07};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op = base_ops[$urandom_range(0, 9)];
            a = pick(); b = pick();
            e = model(op, a, b);
            bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== e.res || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL back_to_back[%0d] got v=%b r=%h rdy=%b want v=1 r=%h rdy=1",
                    i, bus.out_valid, bus.result, bus.in_ready, e.res);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        e1 = model(5'h00, a1, b1);
        e2 = model(5'h08, a2, b2);
        bus.out_ready = 1'b0;
        bus.op = 5'h00; bus.a = a1; bus.b = b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.a = $urandom; bus.b = $urandom;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== e1.res || bus.in_ready !== 1'b0 ||
                {bus.cflag, bus.oflag} !== {e1.c, e1.o}) begin
                errors++; $display("FAIL hold[%0d] got v=%b r=%h rdy=%b co=%b%b want v=1 r=%h rdy=0 co=%b%b",
                    k, bus.out_valid, bus.result, bus.in_ready, bus.cflag, bus.oflag, e1.res, e1.c, e1.o);
            end
            @(negedge clk);
            checks++;
            if (bus.result !== e1.res) begin errors++; $display("FAIL hold_negedge[%0d] got %h want %h", k, bus.result, e1.res); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.op = 5'h08; bus.a = a2; bus.b = b2; bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== e2.res || bus.cflag !== e2.c) begin
            errors++; $display("FAIL hold_no_bubble got v=%b r=%h c=%b want v=1 r=%h c=%b",
                bus.out_valid, bus.result, bus.cflag, e2.res, e2.c);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res; logic [3:0] flg; logic busy_ok; int seen;
        bus.out_ready = 1'b1;
        bus.op = 5'h10; bus.a = $urandom; bus.b = $urandom; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_mul got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
        issue(5'h00, 32'd5, 32'd6, lat, res, flg, busy_ok);
        checks++;
        if (lat != 1 || res !== 32'd11) begin errors++; $display("FAIL flush_then_add got lat=%0d r=%h want lat=1 r=0000000b", lat, res); end
        // Flush while holding a result.
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got v=%b want 0", bus.out_valid); end
        // A request presented together with flush is dropped.
        bus.out_ready = 1'b1;
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 5'h00; bus.a = 32'd1; bus.b = 32'd2;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_beats_accept got v=%b want 0", bus.out_valid); end
        issue(5'h06, 32'h0000_00F0, 32'h0000_0F00, lat, res, flg, busy_ok);
        checks++;
        if (res !== 32'h0000_0FF0) begin errors++; $display("FAIL pre_reset_or got %h want 00000ff0", res); end
    endtask

    task automatic test_reset_mid_div();
        int seen; int lat; logic [31:0] res; logic [3:0] flg; logic busy_ok;
        bus.op = 5'h15; bus.a = $urandom | 32'h8000_0000; bus.b = 32'($urandom_range(1, 1000));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.result, bus.zflag, bus.nflag, bus.cflag, bus.oflag} !== 37'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset got v=%b r=%h rdy=%b want v=0 r=0 rdy=1", bus.out_valid, bus.result, bus.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
        checks++;
        if (seen != 0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_no_stale got %0d valid cycles rdy=%b want 0 rdy=1", seen, bus.in_ready);
        end
        issue(5'h17, 32'd100, 32'd7, lat, res, flg, busy_ok);
        checks++;
        if (res !== 32'd2 || lat != 33) begin errors++; $display("FAIL reset_recover got r=%h lat=%0d want r=2 lat=33", res, lat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked execute unit. It extends the single-cycle integer ALU with a registered output stage, correct unsigned compares, and the RV32M multiply/divide operations, implemented iteratively. It sits in the EX stage between operand forwarding and the EX/MEM register, and stalls the pipeline through a valid/ready handshake while a multi-cycle operation runs.

## Interface
- `XLEN`, 32: operand and result width; must be ≥ 8 and a power of two.
- `SHW`, $clog2(XLEN): shift-amount width; derived, do not override.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request this cycle.
- `op` in 5: {mext, instr[30], funct3}. With mext=0: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND. With mext=1, funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; instr[30] is ignored.
- `a`, `b` in XLEN: operands; sampled only at acceptance.
- `flush` in 1: synchronous abort of any in-flight or held operation.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: registered result.
- `zflag`, `nflag`, `cflag`, `oflag` out 1 each: registered flags.

## Operation
- The unit has four states: IDLE, MUL, DIV and HOLD.
- **Acceptance:** a request is accepted on a cycle where `in_valid && in_ready`.
- **`in_ready` rule:** `in_ready` = (state==IDLE) || (state==HOLD && out_ready), so back-to-back operations run without a bubble.
- **Base ops:** the result is computed combinationally and registered at acceptance, and the unit goes to HOLD.
  - Shifts use `b[SHW-1:0]` only.
  - SLT is a signed compare; SLTU is an unsigned compare.
  - Undefined `op` encodings give result 0, `cflag`=0 and `oflag`=0.
- **Multiply:** state MUL, radix-2 shift-add over XLEN iterations, producing a 2·XLEN product.
  - Signed operands (MULH both signed; MULHSU `a` only) are converted to magnitude, multiplied unsigned, and the product is negated if the signs differ.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- **Divide:** state DIV, restoring division over XLEN iterations.
  - Signed divide is done on magnitudes. The quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- **Divide fast paths:** these finish in 1 cycle like base ops and never enter DIV.
  - Divide by zero: quotient all-ones, remainder = `a`.
  - Signed overflow (`a`=most-negative, `b`=−1): quotient = `a`, remainder = 0.
- **Flags:**
  - `zflag` = (result==0) and `nflag` = result[XLEN−1], for every op.
  - ADD: `cflag` = carry out of bit XLEN−1; `oflag` = signed overflow.
  - SUB: `cflag` = (a ≥ b unsigned), i.e. no borrow; `oflag` = signed overflow.
  - All other ops: `cflag` = `oflag` = 0.
- **HOLD:** `out_valid`=1 and outputs are stable until `out_ready`. On `out_ready`, the unit returns to IDLE, or takes the new request if one is accepted the same cycle.
- **Flush:** from any state, the unit goes to IDLE and drops `out_valid` the next cycle. A request presented with `flush` is ignored; flush has priority over accept.

## Timing
- **Reset:** `out_valid`=0, `result`=0, all flags 0, state IDLE, iteration counter 0, so `in_ready`=1 during and after reset.
- **Reset mid-operation:** asynchronous reset aborts immediately; no stale result appears afterwards.
- **Latency** (acceptance edge t to first cycle with `out_valid`=1):
  - Base ops and divide fast paths: t+1.
  - MUL*/DIV*/REM*: t+XLEN+1, i.e. 33 cycles for XLEN=32.
- **Counter:** runs from 0 to XLEN−1 and is cleared on acceptance and on flush.
- **While in MUL or DIV:** `in_ready`=0; operand changes on `a`/`b` have no effect.
- **Back-pressure:** with `out_ready`=0, `result` and the flags are held indefinitely with no glitch.
- **Throughput:** base ops sustain 1 op/cycle while `out_ready`=1.

## Test plan
- ADD a=0xFFFFFFFF, b=1 → result 0, z=1, c=1, o=0, `out_valid` exactly 1 cycle after acceptance. SUB a=0x80000000, b=1 → 0x7FFFFFFF, o=1, c=1.
- a=0xFFFFFFFF, b=1 → SLT 1, SLTU 0. SRA a=0x80000000, b=0x21 (shamt 1) → 0xC0000000. SRL with the same operands → 0x40000000.
- a=0xFFFFFFFF, b=2 → MUL 0xFFFFFFFE, MULH 0xFFFFFFFF, MULHU 0x00000001, MULHSU 0xFFFFFFFF. Each result appears at latency 33, with `in_ready`=0 throughout.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7, both at latency 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Hold `out_ready` low for 5 cycles after an ADD → outputs stable and `in_ready`=0. Raise `out_ready` together with a new request → new result the next cycle, with no bubble.
- Assert `flush` at iteration 10 of a MUL → `out_valid` never rises and the next ADD completes at latency 1. Pulse `rst_n` low mid-DIV → all outputs 0 asynchronously and `in_ready`=1 after release.
